adpll_lock_detect: RTL

- Lock-quality monitor downstream of the PI loop filter in the ADPLL.
- Consumes the synchronized up/down phase-error pulses and the signed 13-bit filter word K.
- Judges each fixed observation window and asserts `locked` after enough consecutive quiet, stable windows.
- Drops `locked` after enough consecutive bad windows; exports state and a one-cycle loss-of-lock pulse for system control.

---
 rtl/adpll_pkg.sv | 24 ++
 rtl/lock_window_stats.sv | 78 +++++++
 rtl/adpll_lock_detect.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL constants, lock-state encoding and default lock-detector tuning.
// Used by the PI filter, DCO and the lock detector.
package adpll_pkg;

   localparam int K_WIDTH            = 13;
   localparam int WINDOW_LEN_DEF     = 1024;
   localparam int PULSE_TOL_DEF      = 4;
   localparam int K_TOL_DEF          = 3;
   localparam int LOCK_WINDOWS_DEF   = 4;
   localparam int UNLOCK_WINDOWS_DEF = 2;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLDOVER = 2'd3
   } lock_state_e;

   // 8-bit saturating increment for the window run counters
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/lock_window_stats.sv
// Per-window statistics: window counter, saturating pulse count, K min/max.
// ADPLL_LOCK_KCENTER_EN adds the o_kmid midpoint output.
module lock_window_stats
   import adpll_pkg::*;
#(
   parameter int WINDOW_LEN = WINDOW_LEN_DEF,
   parameter int PULSE_TOL  = PULSE_TOL_DEF,
   parameter int K_TOL      = K_TOL_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_up,
   input  logic                      i_down,
   input  logic signed [K_WIDTH-1:0] i_k,
   output logic                      o_win_end,
   output logic                      o_good,
   output logic [7:0]                o_pulses
`ifdef ADPLL_LOCK_KCENTER_EN
   ,
   output logic signed [K_WIDTH-1:0] o_kmid
`endif
);

   localparam int CW = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;

   logic [CW-1:0]              r_cnt;
   logic [7:0]                 r_acc;
   logic signed [K_WIDTH-1:0]  r_kmin;
   logic signed [K_WIDTH-1:0]  r_kmax;

   logic                       w_first;
   logic [8:0]                 w_sum;
   logic [7:0]                 w_acc;
   logic signed [K_WIDTH-1:0]  w_kmin;
   logic signed [K_WIDTH-1:0]  w_kmax;
   logic [K_WIDTH:0]           w_range;

   assign w_first   = (r_cnt == '0);
   assign o_win_end = (r_cnt == CW'(WINDOW_LEN - 1));

   // Running statistics including the current cycle, so window end sees its own inputs
   always_comb begin
      w_sum = {1'b0, (w_first ? 8'd0 : r_acc)} + {8'd0, i_up} + {8'd0, i_down};
      w_acc = w_sum[8] ? 8'hFF : w_sum[7:0];
      w_kmin = i_k;
      w_kmax = i_k;
      if (!w_first) begin
         w_kmin = (i_k < r_kmin) ? i_k : r_kmin;
         w_kmax = (i_k > r_kmax) ? i_k : r_kmax;
      end
      w_range = {w_kmax[K_WIDTH-1], w_kmax} - {w_kmin[K_WIDTH-1], w_kmin};
   end

   assign o_pulses = w_acc;
   assign o_good   = (w_acc <= 8'(PULSE_TOL)) && (w_range <= (K_WIDTH+1)'(K_TOL));

`ifdef ADPLL_LOCK_KCENTER_EN
   logic signed [K_WIDTH:0] w_ksum;
   assign w_ksum = {w_kmin[K_WIDTH-1], w_kmin} + {w_kmax[K_WIDTH-1], w_kmax};
   assign o_kmid = K_WIDTH'(w_ksum >>> 1);
`endif

   // Window position and accumulated statistics; reset drops any partial window
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_kmin <= '0;
         r_kmax <= '0;
      end else begin
         r_cnt  <= o_win_end ? '0 : r_cnt + 1'b1;
         r_acc  <= w_acc;
         r_kmin <= w_kmin;
         r_kmax <= w_kmax;
      end
   end

endmodule

// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: judges fixed windows and runs the lock/holdover FSM.
// ADPLL_LOCK_KCENTER_EN adds the k_center output (K midpoint while locked).
module adpll_lock_detect
   import adpll_pkg::*;
#(
   parameter int WINDOW_LEN     = WINDOW_LEN_DEF,
   parameter int PULSE_TOL      = PULSE_TOL_DEF,
   parameter int K_TOL          = K_TOL_DEF,
   parameter int LOCK_WINDOWS   = LOCK_WINDOWS_DEF,
   parameter int UNLOCK_WINDOWS = UNLOCK_WINDOWS_DEF
) (
   input  logic                      ID_clk,
   input  logic                      rst,
   input  logic                      up_pulse,
   input  logic                      down_pulse,
   input  logic signed [K_WIDTH-1:0] k_in,
   output logic                      locked,
   output logic                      lock_lost,
   output logic [1:0]                lock_state,
   output logic [7:0]                win_pulses
`ifdef ADPLL_LOCK_KCENTER_EN
   ,
   output logic signed [K_WIDTH-1:0] k_center
`endif
);

   lock_state_e r_state, w_nstate;
   logic [7:0]  r_good_cnt, w_ngood;
   logic [7:0]  r_bad_cnt, w_nbad;
   logic        r_locked, r_lost;
   logic [7:0]  r_win_pulses;
   logic        w_win_end, w_good;
   logic [7:0]  w_pulses;

`ifdef ADPLL_LOCK_KCENTER_EN
   logic signed [K_WIDTH-1:0] w_kmid;
   logic signed [K_WIDTH-1:0] r_kcenter;
`endif

   lock_window_stats #(
      .WINDOW_LEN (WINDOW_LEN),
      .PULSE_TOL  (PULSE_TOL),
      .K_TOL      (K_TOL)
   ) u_stats (
      .i_clk     (ID_clk),
      .i_rst     (rst),
      .i_up      (up_pulse),
      .i_down    (down_pulse),
      .i_k       (k_in),
      .o_win_end (w_win_end),
      .o_good    (w_good),
      .o_pulses  (w_pulses)
`ifdef ADPLL_LOCK_KCENTER_EN
      ,
      .o_kmid    (w_kmid)
`endif
   );

   // Next state and run counters; only a window end can move the FSM
   always_comb begin
      w_nstate = r_state;
      w_ngood  = r_good_cnt;
      w_nbad   = r_bad_cnt;
      if (w_win_end) begin
         unique case (r_state)
            ST_UNLOCKED: begin
               if (w_good) begin
                  if (LOCK_WINDOWS <= 1) begin
                     w_nstate = ST_LOCKED;
                     w_ngood  = 8'd0;
                  end else begin
                     w_nstate = ST_ACQUIRE;
                     w_ngood  = 8'd1;
                  end
               end
            end
            ST_ACQUIRE: begin
               if (!w_good) begin
                  w_nstate = ST_UNLOCKED;
                  w_ngood  = 8'd0;
               end else if (int'(r_good_cnt) + 1 >= LOCK_WINDOWS) begin
                  w_nstate = ST_LOCKED;
                  w_ngood  = 8'd0;
               end else begin
                  w_ngood  = sat_inc8(r_good_cnt);
               end
            end
            ST_LOCKED: begin
               if (!w_good) begin
                  if (UNLOCK_WINDOWS <= 1) begin
                     w_nstate = ST_UNLOCKED;
                     w_nbad   = 8'd0;
                  end else begin
                     w_nstate = ST_HOLDOVER;
                     w_nbad   = 8'd1;
                  end
               end
            end
            ST_HOLDOVER: begin
               if (w_good) begin
                  w_nstate = ST_LOCKED;
                  w_nbad   = 8'd0;
               end else if (int'(r_bad_cnt) + 1 >= UNLOCK_WINDOWS) begin
                  w_nstate = ST_UNLOCKED;
                  w_nbad   = 8'd0;
               end else begin
                  w_nbad   = sat_inc8(r_bad_cnt);
               end
            end
         endcase
      end
   end

   // State, lock flag, loss-of-lock pulse and last-window pulse count
   always_ff @(posedge ID_clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_UNLOCKED;
         r_good_cnt   <= '0;
         r_bad_cnt    <= '0;
         r_locked     <= 1'b0;
         r_lost       <= 1'b0;
         r_win_pulses <= '0;
      end else begin
         r_state    <= w_nstate;
         r_good_cnt <= w_ngood;
         r_bad_cnt  <= w_nbad;
         r_locked   <= (w_nstate == ST_LOCKED) || (w_nstate == ST_HOLDOVER);
         r_lost     <= r_locked && (w_nstate == ST_UNLOCKED);
         if (w_win_end) r_win_pulses <= w_pulses;
      end
   end

`ifdef ADPLL_LOCK_KCENTER_EN
   // Track the K midpoint of every good window that leaves the FSM in LOCKED
   always_ff @(posedge ID_clk or posedge rst) begin
      if (rst)
         r_kcenter <= '0;
      else if (w_win_end && w_good && (w_nstate == ST_LOCKED))
         r_kcenter <= w_kmid;
   end
   assign k_center = r_kcenter;
`endif

   assign locked     = r_locked;
   assign lock_lost  = r_lost;
   assign lock_state = r_state;
   assign win_pulses = r_win_pulses;

endmodule
